seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. It reuses one CHUNK-bit carry-propagate slice over WIDTH/CHUNK cycles to produce a WIDTH-bit result.
- It generalises the fixed 8/16/32-bit ripple adders to any width. It adds a registered carry chain, subtract mode, signed-overflow flag and valid/ready handshakes.
- It sits between operand sources and result consumers in the datapath, where area matters more than latency.

---
 rtl/seq_chunk_adder.sv | 173 +++++++++++++++++
 tb/tb_seq_chunk_adder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Purpose  : Multi-cycle adder/subtractor. A single CHUNK-bit carry-propagate
//            slice is reused over NCH = WIDTH/CHUNK cycles to build a WIDTH-bit
//            result, trading latency for area. It has a registered carry
//            chain, a subtract mode, a signed-overflow flag and valid/ready
//            handshakes on both sides.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - operand request
//            in_ready  - block idle and able to accept operands
//            a, b      - WIDTH-bit operands
//            cin       - carry-in (add) / borrow-in (sub)
//            sub       - 0: a+b+cin, 1: a-b-cin
//            out_valid - result available
//            out_ready - consumer accepts result
//            sum       - WIDTH-bit result, modulo 2^WIDTH
//            cout      - carry out of the MSB (sub mode: 1 = no borrow)
//            ovf       - two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand registers shift right by CHUNK each CALC cycle so the slice
    // always reads the low CHUNK bits; no index multiplexer is needed.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_shift;

    // ------------------------------------------------------------------
    // Chunk slice
    // ------------------------------------------------------------------
    assign w_a_chunk   = r_a[CHUNK-1:0];
    assign w_b_chunk   = r_b[CHUNK-1:0];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                       + {{CHUNK{1'b0}}, r_carry};

    // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ c.
    // On the last chunk this is the carry into bit WIDTH-1.
    assign w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1]
                     ^ w_chunk_sum[CHUNK-1];

    // Result chunks enter at the top and move down; after NCH chunks the
    // first chunk has reached bit 0 and the word is aligned.
    assign w_sum_shift = (r_sum >> CHUNK)
                       | (WIDTH'(w_chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    assign w_last   = (r_idx == c_last_idx);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~cin, i.e. a - b - cin.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_idx   <= '0;
        end else if (r_state == S_CALC) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunk_sum[CHUNK];
            r_sum   <= w_sum_shift;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_chunk_sum[CHUNK];
                r_ovf  <= w_msb_cin ^ w_chunk_sum[CHUNK];
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Purpose  : Self-checking bench for seq_chunk_adder. A 32/8 instance runs a
//            directed vector table plus backpressure and mid-operation reset
//            sequences; three further instances (32/32, 32/1, 24/6) run
//            random operands against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

    logic clk;
    logic rst;
    logic rst_s;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed instance, WIDTH=32 CHUNK=8
    // ------------------------------------------------------------------
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        string       name;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // Called at a negedge with the DUT idle; returns at the first negedge
    // where out_valid is seen, with lat = edges from accept to out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub, output int lat);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cin      = ~tcin;
        sub      = ~tsub;
        lat      = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Random sweep instances
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W   = (gi == 2) ? 24 : 32;
        localparam int C   = (gi == 0) ? 32 : ((gi == 1) ? 1 : 6);
        localparam int NCH = W / C;

        logic         s_in_valid;
        logic         s_in_ready;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;
        logic         s_cin;
        logic         s_sub;
        logic         s_out_valid;
        logic         s_out_ready;
        logic [W-1:0] s_sum;
        logic         s_cout;
        logic         s_ovf;
        logic         done;

        seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst_s),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .sub       (s_sub),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum       (s_sum),
            .cout      (s_cout),
            .ovf       (s_ovf)
        );

        initial begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            longint       ua;
            longint       ub;
            longint       sa;
            longint       sb;
            longint       md;
            longint       full;
            longint       sres;
            logic [W-1:0] es;
            logic         ec;
            logic         eo;
            int           lat;
            int           stall;

            done        = 1'b0;
            s_in_valid  = 1'b0;
            s_out_ready = 1'b0;
            s_a         = '0;
            s_b         = '0;
            s_cin       = 1'b0;
            s_sub       = 1'b0;
            md          = longint'(1) << W;
            @(negedge clk);
            while (rst_s) @(negedge clk);

            for (int n = 0; n < 1000; n++) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                if (n % 50 == 0) begin
                    ra = '1;
                    rb = (rs) ? '0 : W'(1);
                end
                s_a        = ra;
                s_b        = rb;
                s_cin      = rc;
                s_sub      = rs;
                s_in_valid = 1'b1;
                @(negedge clk);
                s_in_valid = 1'b0;
                s_cin      = ~rc;
                s_sub      = ~rs;
                lat        = 0;
                while (!s_out_valid && lat < 2 * W + 8) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("sweep%0d_latency", gi), 64'(lat), 64'(NCH));

                ua = longint'(ra);
                ub = longint'(rb);
                sa = ra[W-1] ? ua - md : ua;
                sb = rb[W-1] ? ub - md : ub;
                if (rs) begin
                    full = ua - ub - longint'(rc);
                    sres = sa - sb - longint'(rc);
                    ec   = (full >= 0);
                end else begin
                    full = ua + ub + longint'(rc);
                    sres = sa + sb + longint'(rc);
                    ec   = (full >= md);
                end
                es = W'(full);
                eo = (sres >= md / 2) || (sres < -(md / 2));

                stall = $urandom_range(0, 3);
                repeat (stall) @(negedge clk);
                check($sformatf("sweep%0d_result", gi),
                      64'({s_out_valid, s_cout, s_ovf, s_sum}),
                      64'({1'b1, ec, eo, es}));

                s_out_ready = 1'b1;
                @(negedge clk);
                s_out_ready = 1'b0;
                check($sformatf("sweep%0d_release", gi),
                      64'({s_in_ready, s_out_valid}), 64'(2'b10));
            end
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int          lat;
        logic [31:0] hold_sum;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap"};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf"};
        vecs[2]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, "add_cin"};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg"};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf"};
        vecs[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, "sub_borrow_in"};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, "add_zero_cin"};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "add_neg_ovf"};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_zero"};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_zero_bin"};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "add_ones_cin"};
        vecs[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, "sub_max_m1"};
        vecs[12] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, "add_chunk_carry"};

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        rst_s     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({in_ready, out_valid, cout, ovf, sum}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
        rst   = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd4);
            check({vecs[i].name, "_sum"}, 64'(sum), 64'(vecs[i].exp_sum));
            check({vecs[i].name, "_cout"}, 64'(cout), 64'(vecs[i].exp_cout));
            check({vecs[i].name, "_ovf"}, 64'(ovf), 64'(vecs[i].exp_ovf));
            finish_op();
            check({vecs[i].name, "_release"}, 64'({in_ready, out_valid}), 64'(2'b10));
        end

        // Backpressure: result must hold and new requests must be refused.
        run_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, lat);
        check("bp_latency", 64'(lat), 64'd4);
        hold_sum = 32'h0000_5555;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 32'hDEAD_BEEF;
                b        = 32'h1111_1111;
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_hold", 64'({out_valid, in_ready, cout, ovf, sum}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, hold_sum}));
        end
        finish_op();
        check("bp_release", 64'({in_ready, out_valid}), 64'(2'b10));
        check("bp_keep_sum", 64'(sum), 64'(hold_sum));
        run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, lat);
        check("bp_next_latency", 64'(lat), 64'd4);
        check("bp_next_result", 64'({cout, ovf, sum}), 64'({1'b1, 1'b0, 32'h0}));
        finish_op();

        // Reset on the second CALC cycle, with a carry pending in the chain.
        a        = 32'h0000_00FF;
        b        = 32'h0000_0003;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_calc_state", 64'({in_ready, out_valid, sum}),
              64'({1'b1, 1'b0, 32'h0}));
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, lat);
        check("rst_next_latency", 64'(lat), 64'd4);
        check("rst_next_result", 64'({cout, ovf, sum}), 64'({1'b0, 1'b0, 32'h7}));
        finish_op();

        begin
            int t;
            t = 0;
            while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)
                   && t < 60000) begin
                @(negedge clk);
                t++;
            end
            check("sweep_complete",
                  64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}),
                  64'(3'b111));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
